// File: rtl/life_gen.sv
// rtl/life_gen.sv - Game of Life generation engine; define LIFE_WRAP_EN for a toroidal board
module life_gen #(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   nxt_bit,
  input  logic [LOG2X+LOG2Y-1:0] cnt,
  input  logic                   load_en,
  input  logic [X*Y-1:0]         load_data,
  output logic [X*Y-1:0]         board,
  output logic                   gen_done,
  output logic [15:0]            gen_cnt
);

  localparam int N = X * Y;
  localparam int W = LOG2X + LOG2Y;

  logic [N-1:0]     shadow;
  logic [N-1:0]     shadow_upd;
  logic [3:0]       nbr;
  logic             next_val;
  logic [LOG2Y-1:0] row;
  logic [LOG2X-1:0] col;
  int               ri;
  int               ci;
  logic             in_rng;
  logic [W-1:0]     idx;

  assign row = cnt[W-1:LOG2X];
  assign col = cnt[LOG2X-1:0];

  // Neighbours are always read from the committed board so the sweep order never matters.
  always_comb begin
    nbr    = '0;
    ri     = 0;
    ci     = 0;
    in_rng = 1'b0;
    idx    = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
`ifdef LIFE_WRAP_EN
        ri     = (int'(row) + dr) & (Y - 1);
        ci     = (int'(col) + dc) & (X - 1);
        in_rng = 1'b1;
`else
        ri     = int'(row) + dr;
        ci     = int'(col) + dc;
        in_rng = (ri >= 0) && (ri < Y) && (ci >= 0) && (ci < X);
`endif
        idx = W'(ri * X + ci);
        if (in_rng && !(dr == 0 && dc == 0)) begin
          nbr = nbr + {3'b000, board[idx]};
        end
      end
    end
    next_val        = (nbr == 4'd3) | (board[cnt] & (nbr == 4'd2));
    shadow_upd      = shadow;
    shadow_upd[cnt] = next_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      board    <= '0;
      shadow   <= '0;
      gen_done <= 1'b0;
      gen_cnt  <= '0;
    end else if (load_en) begin
      board    <= load_data;
      shadow   <= load_data;
      gen_done <= 1'b0;
      gen_cnt  <= '0;
    end else begin
      gen_done <= 1'b0;
      if (nxt_bit) begin
        shadow <= shadow_upd;
        // Last index commits, folding in the value computed this very cycle.
        if (cnt == W'(N - 1)) begin
          board    <= shadow_upd;
          gen_cnt  <= gen_cnt + 16'd1;
          gen_done <= 1'b1;
        end
      end
    end
  end

endmodule
